// File: rtl/mc_datapath_if.sv
// Bundle of control inputs and datapath status outputs for mc_datapath.
// The controller side drives the master modport; the datapath uses slave.
interface mc_datapath_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 2
);
  logic [AW-1:0]    rs;
  logic [AW-1:0]    rt;
  logic [AW-1:0]    rd;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] mem_data;
  logic             ab_we;
  logic             aluout_we;
  logic             mdr_we;
  logic             reg_write;
  logic             reg_dst;
  logic [1:0]       wb_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_op;
  logic             mul_start;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_out_q;
  logic             alu_ovf_q;
  logic [1:0]       alu_cmp;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  modport master (
    output rs, rt, rd, imm, pc, pc_next, mem_data, ab_we, aluout_we, mdr_we,
           reg_write, reg_dst, wb_src, alu_src_a, alu_src_b, alu_op, mul_start,
    input  a_q, b_q, alu_out_q, alu_ovf_q, alu_cmp, mul_busy, mul_done,
           mul_hi, mul_lo
  );

  modport slave (
    input  rs, rt, rd, imm, pc, pc_next, mem_data, ab_we, aluout_we, mdr_we,
           reg_write, reg_dst, wb_src, alu_src_a, alu_src_b, alu_op, mul_start,
    output a_q, b_q, alu_out_q, alu_ovf_q, alu_cmp, mul_busy, mul_done,
           mul_hi, mul_lo
  );
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle CPU datapath: register file, A/B/MDR/ALUOut latches, ALU with
// signed overflow and compare, and a sequential shift-add unsigned multiplier.
module mc_datapath #(
  parameter int WIDTH    = 16,
  parameter int NREG     = 4,
  parameter int LINK_REG = 2
) (
  input  logic          clk,
  input  logic          reset,
  mc_datapath_if.slave  bus
);
  localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int CW   = $clog2(WIDTH);
  localparam int HALF = WIDTH / 2;

  typedef enum logic {IDLE, RUN} mul_state_t;

  logic [WIDTH-1:0]   regs [NREG];
  logic [WIDTH-1:0]   a_reg, b_reg, mdr_reg, alu_out_reg;
  logic               ovf_reg;
  logic [AW-1:0]      wr_idx;
  logic [WIDTH-1:0]   wb_data;
  logic [WIDTH-1:0]   op_a, op_b, alu_res;
  logic               alu_ovf;

  mul_state_t         state_reg, state_next;
  logic [2*WIDTH-1:0] mcand_reg, acc_reg, acc_sum;
  logic [WIDTH-1:0]   mplier_reg, hi_reg, lo_reg;
  logic [CW-1:0]      cnt_reg;
  logic               done_reg, busy, last;

  // Write-back index and data selection; the link write always targets LINK_REG
  always_comb begin
    wr_idx = bus.reg_dst ? bus.rd : bus.rt;
    if (bus.wb_src == 2'd2) wr_idx = AW'(LINK_REG);
    case (bus.wb_src)
      2'd0:    wb_data = alu_out_reg;
      2'd1:    wb_data = mdr_reg;
      2'd2:    wb_data = bus.pc_next;
      default: wb_data = lo_reg;
    endcase
  end

  // Register file write port; reads are combinational so same-edge reads see old data
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset) regs[i] <= '0;
      else if (bus.reg_write && wr_idx == AW'(i)) regs[i] <= wb_data;
    end
  end

  // Operand and result latches
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      mdr_reg     <= '0;
      alu_out_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      if (bus.ab_we) begin
        a_reg <= regs[bus.rs];
        b_reg <= regs[bus.rt];
      end
      if (bus.mdr_we) mdr_reg <= bus.mem_data;
      if (bus.aluout_we) begin
        alu_out_reg <= alu_res;
        ovf_reg     <= alu_ovf;
      end
    end
  end

  // ALU operand muxes, operation decode and signed overflow for ADD/SUB
  always_comb begin
    case (bus.alu_src_a)
      2'd0:    op_a = a_reg;
      2'd1:    op_a = bus.pc;
      default: op_a = bus.pc_next;
    endcase
    case (bus.alu_src_b)
      2'd0:    op_b = b_reg;
      2'd1:    op_b = bus.imm;
      2'd2:    op_b = WIDTH'(1);
      default: op_b = '0;
    endcase
    alu_ovf = 1'b0;
    case (bus.alu_op)
      4'd0: begin
        alu_res = op_a + op_b;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'd1: begin
        alu_res = op_a - op_b;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = ~op_a;
      4'd6:    alu_res = -op_a;
      4'd7:    alu_res = op_a << 1;
      4'd8:    alu_res = {op_a[WIDTH-1], op_a[WIDTH-1:1]};
      4'd9:    alu_res = op_a >> 1;
      4'd10:   alu_res = op_b << HALF;
      4'd11:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Multiplier FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Multiplier next-state; start is only honoured from IDLE
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: if (bus.mul_start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        last = (cnt_reg == CW'(WIDTH - 1));
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Shift-add iteration: one multiplier bit per RUN cycle, product published on the last
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE && bus.mul_start) begin
        mcand_reg  <= {{WIDTH{1'b0}}, a_reg};
        mplier_reg <= b_reg;
        acc_reg    <= '0;
        cnt_reg    <= '0;
      end else if (busy) begin
        acc_reg    <= acc_sum;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + 1'b1;
        if (last) begin
          {hi_reg, lo_reg} <= acc_sum;
          done_reg         <= 1'b1;
        end
      end
    end
  end

  assign bus.a_q       = a_reg;
  assign bus.b_q       = b_reg;
  assign bus.alu_out_q = alu_out_reg;
  assign bus.alu_ovf_q = ovf_reg;
  assign bus.alu_cmp   = ($signed(op_a) < $signed(op_b)) ? 2'b01 :
                         ($signed(op_a) > $signed(op_b)) ? 2'b10 : 2'b00;
  assign bus.mul_busy  = busy;
  assign bus.mul_done  = done_reg;
  assign bus.mul_hi    = hi_reg;
  assign bus.mul_lo    = lo_reg;
endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath (WIDTH=16, NREG=4).
module tb_mc_datapath;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  mc_datapath_if #(.WIDTH(16), .AW(2)) bus ();
  mc_datapath #(.WIDTH(16), .NREG(4), .LINK_REG(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic sb_pop_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (sb_q.size() == 0) e = 'x;
    else e = sb_q.pop_front();
    check(tag, got, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    bus.ab_we = 0; bus.aluout_we = 0; bus.mdr_we = 0; bus.reg_write = 0;
    bus.mul_start = 0; bus.reg_dst = 1; bus.wb_src = 0;
    bus.alu_src_a = 0; bus.alu_src_b = 0; bus.alu_op = 0;
  endtask

  task automatic write_reg(input logic [1:0] idx, input logic [15:0] val);
    bus.imm = val; bus.alu_src_b = 1; bus.alu_op = 4'd11; bus.aluout_we = 1;
    step();
    bus.aluout_we = 0; bus.wb_src = 0; bus.reg_dst = 1; bus.rd = idx; bus.reg_write = 1;
    step();
    idle_ctrl();
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [15:0] val);
    bus.rs = idx; bus.ab_we = 1;
    step();
    bus.ab_we = 0;
    val = bus.a_q;
  endtask

  task automatic latch_ab(input logic [1:0] s, input logic [1:0] t);
    bus.rs = s; bus.rt = t; bus.ab_we = 1;
    step();
    bus.ab_we = 0;
  endtask

  // Steps until mul_done, counting sampled cycles (first sample = 1) and busy samples
  task automatic wait_done(input int bound, output int cycles, output int busy_cnt, output bit seen);
    cycles = 1; busy_cnt = 0; seen = 0;
    forever begin
      if (bus.mul_busy) busy_cnt++;
      if (bus.mul_done) begin seen = 1; return; end
      if (cycles >= bound) return;
      step();
      cycles++;
    end
  endtask

  function automatic logic [16:0] alu_model(input int op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic o;
    o = 0;
    case (op)
      0: begin r = a + b; o = (a[15] == b[15]) && (r[15] != a[15]); end
      1: begin r = a - b; o = (a[15] != b[15]) && (r[15] != a[15]); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = 16'd0 - a;
      7: r = {a[14:0], 1'b0};
      8: r = {a[15], a[15:1]};
      9: r = {1'b0, a[15:1]};
      10: r = {b[7:0], 8'h00};
      11: r = b;
      default: r = 16'h0000;
    endcase
    return {o, r};
  endfunction

  initial begin
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] v;
    logic [1:0]  ec;
    int cyc, bc, dcnt;
    bit seen;
    va[0] = 16'h7FFF; vb[0] = 16'h0001;
    va[1] = 16'h8000; vb[1] = 16'h0001;
    va[2] = 16'h1234; vb[2] = 16'h00F0;
    va[3] = 16'hFFFF; vb[3] = 16'hFFFF;

    reset = 1;
    bus.rs = 0; bus.rt = 0; bus.rd = 0; bus.imm = 0; bus.pc = 0; bus.pc_next = 0;
    bus.mem_data = 0;
    idle_ctrl();
    step(); step();
    reset = 0;
    check("rst_a", bus.a_q, 0);
    check("rst_alu_out", bus.alu_out_q, 0);
    check("rst_ovf", bus.alu_ovf_q, 0);
    check("rst_busy_done", {bus.mul_busy, bus.mul_done}, 0);
    check("rst_mul", {bus.mul_hi, bus.mul_lo}, 0);

    // ALU sweep over operand pairs; compare, then every opcode through ALUOut
    for (int p = 0; p < 4; p++) begin
      write_reg(2'd1, va[p]);
      write_reg(2'd2, vb[p]);
      latch_ab(2'd1, 2'd2);
      check($sformatf("b_latch_p%0d", p), bus.b_q, vb[p]);
      ec = ($signed(va[p]) < $signed(vb[p])) ? 2'b01 :
           ($signed(va[p]) > $signed(vb[p])) ? 2'b10 : 2'b00;
      check($sformatf("cmp_p%0d", p), bus.alu_cmp, ec);
      for (int op = 0; op < 16; op++) begin
        bus.alu_src_a = 0; bus.alu_src_b = 0; bus.alu_op = op[3:0]; bus.aluout_we = 1;
        sb_q.push_back({15'd0, alu_model(op, va[p], vb[p])});
        step();
        bus.aluout_we = 0;
        sb_pop_check($sformatf("alu_op%0d_p%0d", op, p), {15'd0, bus.alu_ovf_q, bus.alu_out_q});
      end
    end

    // Operand source muxes
    bus.pc = 16'h0100; bus.pc_next = 16'h0102; bus.imm = 16'h0010;
    bus.alu_op = 0; bus.aluout_we = 1;
    bus.alu_src_a = 1; bus.alu_src_b = 2; sb_q.push_back(32'h0101); step();
    sb_pop_check("src_pc_plus1", {16'd0, bus.alu_out_q});
    bus.alu_src_a = 2; bus.alu_src_b = 3; sb_q.push_back(32'h0102); step();
    sb_pop_check("src_pcnext_zero", {16'd0, bus.alu_out_q});
    bus.alu_src_a = 3; bus.alu_src_b = 1; sb_q.push_back(32'h0112); step();
    sb_pop_check("src_pcnext_imm", {16'd0, bus.alu_out_q});
    idle_ctrl();

    // MDR write-back
    bus.mem_data = 16'hBEEF; bus.mdr_we = 1; step(); bus.mdr_we = 0;
    bus.wb_src = 1; bus.reg_dst = 1; bus.rd = 3; bus.reg_write = 1; step(); idle_ctrl();
    read_reg(2'd3, v); check("mdr_wb", v, 16'hBEEF);

    // Link write ignores rd
    write_reg(2'd2, 16'h1111);
    write_reg(2'd3, 16'h5555);
    bus.pc_next = 16'h0042; bus.wb_src = 2; bus.reg_dst = 1; bus.rd = 3; bus.reg_write = 1;
    step(); idle_ctrl();
    read_reg(2'd2, v); check("link_rf2", v, 16'h0042);
    read_reg(2'd3, v); check("link_rf3", v, 16'h5555);

    // Basic multiply
    write_reg(2'd1, 16'h1234);
    write_reg(2'd2, 16'h0100);
    latch_ab(2'd1, 2'd2);
    sb_q.push_back(32'h0012_3400);
    bus.mul_start = 1; step(); bus.mul_start = 0;
    wait_done(40, cyc, bc, seen);
    check("mul1_done_seen", seen, 1);
    check("mul1_busy_cycles", bc, 16);
    check("mul1_done_cycle", cyc, 17);
    sb_pop_check("mul1_product", {bus.mul_hi, bus.mul_lo});
    step();
    check("mul1_done_pulse", {bus.mul_busy, bus.mul_done}, 0);

    // Mid-run restart request, operand relatch and mul_lo write-back are ignored by the product
    write_reg(2'd1, 16'hABCD);
    write_reg(2'd2, 16'h0003);
    latch_ab(2'd1, 2'd2);
    sb_q.push_back(32'h0002_0367);
    bus.mul_start = 1; step(); bus.mul_start = 0;
    step(); step();
    bus.mul_start = 1; bus.ab_we = 1; bus.rs = 3; bus.rt = 3;
    bus.wb_src = 3; bus.reg_dst = 1; bus.rd = 0; bus.reg_write = 1;
    step(); idle_ctrl();
    wait_done(40, cyc, bc, seen);
    check("mul2_done_seen", seen, 1);
    check("mul2_done_cycle", cyc, 14);
    sb_pop_check("mul2_product", {bus.mul_hi, bus.mul_lo});

    // Back-to-back start in the done cycle uses the relatched 0x5555 operands
    sb_q.push_back(32'h5555 * 32'h5555);
    bus.mul_start = 1; step(); bus.mul_start = 0;
    check("mul3_busy_start", bus.mul_busy, 1);
    wait_done(40, cyc, bc, seen);
    check("mul3_done_cycle", cyc, 17);
    sb_pop_check("mul3_product", {bus.mul_hi, bus.mul_lo});
    step();
    read_reg(2'd0, v); check("mul_lo_old_wb", v, 16'h3400);

    // Reset during RUN cycle 5 discards everything, overriding enables
    latch_ab(2'd1, 2'd2);
    bus.mul_start = 1; step(); bus.mul_start = 0;
    step(); step(); step(); step();
    check("mul4_busy_c5", bus.mul_busy, 1);
    reset = 1; bus.reg_write = 1; bus.ab_we = 1; bus.aluout_we = 1; bus.mul_start = 1;
    step();
    reset = 0; idle_ctrl();
    check("rst_run_busy_done", {bus.mul_busy, bus.mul_done}, 0);
    check("rst_run_mul", {bus.mul_hi, bus.mul_lo}, 0);
    check("rst_run_ab", {bus.a_q, bus.b_q}, 0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mul_done || bus.mul_busy) dcnt++;
      step();
    end
    check("rst_run_no_done", dcnt, 0);
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      check($sformatf("rst_rf%0d", i), v, 0);
    end

    // Same-edge write and read: A gets the old value
    write_reg(2'd1, 16'h1111);
    bus.imm = 16'hAAAA; bus.alu_src_b = 1; bus.alu_op = 4'd11; bus.aluout_we = 1;
    step(); idle_ctrl();
    bus.rs = 1; bus.ab_we = 1; bus.wb_src = 0; bus.reg_dst = 1; bus.rd = 1; bus.reg_write = 1;
    step(); idle_ctrl();
    check("nobypass_old", bus.a_q, 16'h1111);
    read_reg(2'd1, v); check("nobypass_new", v, 16'hAAAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
